// File: rtl/spi_arb_pkg.sv
// spi_arb_pkg: shared FSM states, default sizing and width helpers for the SPI master arbiter
package spi_arb_pkg;
  typedef enum logic [2:0] {IDLE, LAUNCH, ACTIVE, DONE, GAP} state_t;
  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_GAP = 64;
  localparam int DEF_TIMEOUT = 1023;
  function automatic int cnt_width(input int gap, input int tmo);
    return $clog2((gap > tmo ? gap : tmo) + 1);
  endfunction
  function automatic int ptr_width(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/spi_rr_picker.sv
// spi_rr_picker: combinational round-robin winner search starting just after last
module spi_rr_picker
  import spi_arb_pkg::*;
#(
  parameter int N = DEF_NUM_REQ,
  parameter int PW = ptr_width(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] last,
  output logic [N-1:0]  win,
  output logic [PW-1:0] idx
);
  logic [PW-1:0] c;
  always_comb begin
    idx = '0;
    c = '0;
    // scan farthest-to-nearest so the closest requester after last wins
    for (int i = N; i >= 1; i--) begin
      c = PW'((int'(last) + i) % N);
      if (req[c]) idx = c;
    end
    win = |req ? N'(1) << idx : '0;
  end
endmodule

// File: rtl/spi_master_arbiter.sv
// spi_master_arbiter: round-robin sharing of one SPI master among NUM_REQ requesters
module spi_master_arbiter
  import spi_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int PACK_LENGTH = 8,
  parameter int GAP_CLOCKS = DEF_GAP,
  parameter int LAUNCH_TIMEOUT = DEF_TIMEOUT
) (
  input  logic                           IN_CLOCK,
  input  logic                           IN_RESET_N,
  input  logic [NUM_REQ-1:0]             IN_REQ,
  input  logic [NUM_REQ*PACK_LENGTH-1:0] IN_REQ_DATA,
  output logic [NUM_REQ-1:0]             OUT_GRANT,
  output logic [NUM_REQ-1:0]             OUT_ACK,
  output logic                           OUT_TIMEOUT,
  output logic [PACK_LENGTH-1:0]         OUT_RX_DATA,
  output logic                           OUT_BUSY,
  output logic                           OUT_LAUNCH_MASTER,
  output logic [PACK_LENGTH-1:0]         OUT_MASTER_DATA,
  input  logic                           IN_MASTER_CS,
  input  logic [PACK_LENGTH-1:0]         IN_MASTER_RECEIVE_DATA
);
  localparam int CW = cnt_width(GAP_CLOCKS, LAUNCH_TIMEOUT);
  localparam int PW = ptr_width(NUM_REQ);
  localparam logic [CW-1:0] TMO_LAST = CW'(LAUNCH_TIMEOUT > 0 ? LAUNCH_TIMEOUT - 1 : 0);
  localparam logic [CW-1:0] GAP_LAST = CW'(GAP_CLOCKS > 0 ? GAP_CLOCKS - 1 : 0);
  localparam logic [PW-1:0] LAST_RST = PW'(NUM_REQ - 1);
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n, cnt_inc;
  logic [PW-1:0] last, last_n, owner, owner_n, win_idx;
  logic [NUM_REQ-1:0] win, grant_n, ack_n;
  logic abort, abort_n, tmo_n, launch_n;
  logic [PACK_LENGTH-1:0] rx_n, mdata_n;
  logic [PACK_LENGTH-1:0] words [NUM_REQ];
  for (genvar k = 0; k < NUM_REQ; k++) begin : g_words
    assign words[k] = IN_REQ_DATA[k*PACK_LENGTH +: PACK_LENGTH];
  end
  spi_rr_picker #(.N(NUM_REQ), .PW(PW)) u_pick (
    .req(IN_REQ),
    .last(last),
    .win(win),
    .idx(win_idx)
  );
  assign cnt_inc = &cnt ? cnt : cnt + 1'b1;
  always_ff @(posedge IN_CLOCK or negedge IN_RESET_N) begin
    if (!IN_RESET_N) begin
      state <= IDLE;
      cnt <= '0;
      last <= LAST_RST;
      owner <= '0;
      abort <= 1'b0;
      OUT_GRANT <= '0;
      OUT_ACK <= '0;
      OUT_TIMEOUT <= 1'b0;
      OUT_RX_DATA <= '0;
      OUT_BUSY <= 1'b0;
      OUT_LAUNCH_MASTER <= 1'b0;
      OUT_MASTER_DATA <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      last <= last_n;
      owner <= owner_n;
      abort <= abort_n;
      OUT_GRANT <= grant_n;
      OUT_ACK <= ack_n;
      OUT_TIMEOUT <= tmo_n;
      OUT_RX_DATA <= rx_n;
      OUT_BUSY <= state_n != IDLE;
      OUT_LAUNCH_MASTER <= launch_n;
      OUT_MASTER_DATA <= mdata_n;
    end
  end
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    last_n = last;
    owner_n = owner;
    abort_n = abort;
    grant_n = OUT_GRANT;
    ack_n = '0;
    tmo_n = 1'b0;
    rx_n = OUT_RX_DATA;
    launch_n = OUT_LAUNCH_MASTER;
    mdata_n = OUT_MASTER_DATA;
    case (state)
      IDLE: if (IN_MASTER_CS && |IN_REQ) begin
        state_n = LAUNCH;
        grant_n = win;
        owner_n = win_idx;
        mdata_n = words[win_idx];
        launch_n = 1'b1;
        abort_n = 1'b0;
        cnt_n = '0;
      end
      LAUNCH: if (!IN_MASTER_CS) begin
        launch_n = 1'b0;
        state_n = ACTIVE;
      end else if (cnt == TMO_LAST) begin
        launch_n = 1'b0;
        abort_n = 1'b1;
        state_n = DONE;
      end else cnt_n = cnt_inc;
      ACTIVE: if (IN_MASTER_CS) begin
        rx_n = IN_MASTER_RECEIVE_DATA;
        state_n = DONE;
      end
      DONE: begin
        ack_n = OUT_GRANT;
        tmo_n = abort;
        last_n = owner;
        grant_n = '0;
        cnt_n = '0;
        state_n = GAP_CLOCKS == 0 ? IDLE : GAP;
      end
      GAP: if (cnt == GAP_LAST) state_n = IDLE;
      else cnt_n = cnt_inc;
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: tb/tb_spi_master_arbiter.sv
// tb_spi_master_arbiter: directed checks of two arbiter configs against a behavioural SPI master
module tb_spi_master_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  logic [3:0] req [2];
  logic [31:0] req_data [2];
  logic [3:0] grant [2];
  logic [3:0] ack [2];
  logic tmo [2];
  logic busy [2];
  logic launch [2];
  logic [7:0] rx [2];
  logic [7:0] mdata [2];
  logic stub [2];
  logic cs [2] = '{1'b1, 1'b1};
  logic [7:0] mrx [2] = '{8'h00, 8'h00};
  logic [7:0] tx_cap [2] = '{8'h00, 8'h00};
  int mc [2] = '{0, 0};
  int nlaunch [2] = '{0, 0};
  int n_chk = 0;
  int n_pass = 0;
  logic [3:0] eg2 [5] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1};
  logic [7:0] em2 [5] = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h10};
  logic [3:0] eg6 [3] = '{4'h2, 4'h8, 4'h2};
  logic [7:0] em6 [3] = '{8'h11, 8'h33, 8'h11};
  spi_master_arbiter #(.NUM_REQ(4), .PACK_LENGTH(8), .GAP_CLOCKS(4), .LAUNCH_TIMEOUT(15)) u_dut (
    .IN_CLOCK(clk), .IN_RESET_N(rst_n), .IN_REQ(req[0]), .IN_REQ_DATA(req_data[0]),
    .OUT_GRANT(grant[0]), .OUT_ACK(ack[0]), .OUT_TIMEOUT(tmo[0]), .OUT_RX_DATA(rx[0]),
    .OUT_BUSY(busy[0]), .OUT_LAUNCH_MASTER(launch[0]), .OUT_MASTER_DATA(mdata[0]),
    .IN_MASTER_CS(cs[0]), .IN_MASTER_RECEIVE_DATA(mrx[0])
  );
  spi_master_arbiter #(.NUM_REQ(4), .PACK_LENGTH(8), .GAP_CLOCKS(0), .LAUNCH_TIMEOUT(15)) u_dut_nogap (
    .IN_CLOCK(clk), .IN_RESET_N(rst_n), .IN_REQ(req[1]), .IN_REQ_DATA(req_data[1]),
    .OUT_GRANT(grant[1]), .OUT_ACK(ack[1]), .OUT_TIMEOUT(tmo[1]), .OUT_RX_DATA(rx[1]),
    .OUT_BUSY(busy[1]), .OUT_LAUNCH_MASTER(launch[1]), .OUT_MASTER_DATA(mdata[1]),
    .IN_MASTER_CS(cs[1]), .IN_MASTER_RECEIVE_DATA(mrx[1])
  );
  // master model: CS low one clock after launch, held 6 clocks, slave returns the complement
  always @(posedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (mc[g] != 0) begin
        mc[g] <= mc[g] - 1;
        if (mc[g] == 1) begin
          cs[g] <= 1'b1;
          mrx[g] <= ~tx_cap[g];
        end
      end else if (launch[g] && cs[g] && !stub[g]) begin
        cs[g] <= 1'b0;
        tx_cap[g] <= mdata[g];
        mc[g] <= 6;
        nlaunch[g] <= nlaunch[g] + 1;
      end
    end
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  task automatic wait_grant(input int g, output logic [3:0] gr, output logic [7:0] md, output int since);
    logic pcs;
    logic [3:0] pg;
    pcs = cs[g];
    pg = grant[g];
    since = -1;
    gr = '0;
    md = '0;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      if (cs[g] && !pcs) since = 0;
      else if (since >= 0) since++;
      pcs = cs[g];
      if (grant[g] != 0 && pg == 0) begin
        gr = grant[g];
        md = mdata[g];
        return;
      end
      pg = grant[g];
    end
  endtask
  task automatic wait_ack(input int g, output logic [3:0] a);
    a = '0;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      if (ack[g] != 0) begin
        a = ack[g];
        return;
      end
    end
  endtask
  task automatic wait_idle(input int g);
    for (int n = 0; n < 400 && (busy[g] || !cs[g]); n++) @(negedge clk);
    chk("idle", 32'({busy[g], cs[g]}), 1);
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask
  initial begin
    logic [3:0] gr;
    logic [3:0] a;
    logic [7:0] md;
    int since;
    int n;
    logic bad;
    req = '{4'h0, 4'h0};
    req_data = '{32'h0, 32'h0};
    stub = '{1'b0, 1'b0};
    repeat (2) @(negedge clk);
    chk("rst_out", 32'({grant[0], ack[0], tmo[0], rx[0], busy[0], launch[0], mdata[0]}), 0);
    chk("rst_out_nogap", 32'({grant[1], ack[1], tmo[1], rx[1], busy[1], launch[1], mdata[1]}), 0);
    rst_n = 1'b1;
    req_data[0] = 32'h000000A5;
    req[0] = 4'b0001;
    wait_grant(0, gr, md, since);
    chk("t1_grant", 32'(gr), 'h1);
    chk("t1_mdata", 32'(md), 'hA5);
    chk("t1_launch", 32'(launch[0]), 1);
    chk("t1_busy", 32'(busy[0]), 1);
    wait_ack(0, a);
    chk("t1_ack", 32'(a), 'h1);
    chk("t1_tmo", 32'(tmo[0]), 0);
    chk("t1_rx", 32'(rx[0]), 'h5A);
    req[0] = 4'b0000;
    @(negedge clk);
    chk("t1_ack_pulse", 32'(ack[0]), 0);
    wait_idle(0);
    chk("t1_nlaunch", 32'(nlaunch[0]), 1);
    do_reset();
    req_data[0] = 32'h40302010;
    req[0] = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      wait_grant(0, gr, md, since);
      chk("t2_grant", 32'(gr), 32'(eg2[i]));
      chk("t2_mdata", 32'(md), 32'(em2[i]));
      if (i > 0) chk("t2_gap", 32'(since), 7);
    end
    req[0] = 4'b0000;
    wait_idle(0);
    do_reset();
    req_data[0] = 32'h00550000;
    req[0] = 4'b0100;
    wait_grant(0, gr, md, since);
    chk("t3_grant", 32'(gr), 'h4);
    chk("t3_mdata", 32'(md), 'h55);
    @(negedge clk);
    req_data[0] = 32'h00FF0000;
    @(negedge clk);
    chk("t3_mdata_hold", 32'(mdata[0]), 'h55);
    wait_ack(0, a);
    chk("t3_ack", 32'(a), 'h4);
    chk("t3_tx", 32'(tx_cap[0]), 'h55);
    chk("t3_rx", 32'(rx[0]), 'hAA);
    req[0] = 4'b0000;
    wait_idle(0);
    stub[0] = 1'b1;
    req_data[0] = 32'h00007700;
    req[0] = 4'b1010;
    wait_grant(0, gr, md, since);
    chk("t4_grant", 32'(gr), 'h8);
    n = 0;
    while (launch[0] && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk("t4_launch_len", 32'(n), 15);
    @(negedge clk);
    chk("t4_ack", 32'(ack[0]), 'h8);
    chk("t4_tmo", 32'(tmo[0]), 1);
    chk("t4_rx_keep", 32'(rx[0]), 'hAA);
    stub[0] = 1'b0;
    req[0] = 4'b0010;
    n = 0;
    while (grant[0] == 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("t4_next_grant", 32'(grant[0]), 'h2);
    chk("t4_gap", 32'(n), 5);
    wait_ack(0, a);
    chk("t4_ack2", 32'(a), 'h2);
    chk("t4_tmo2", 32'(tmo[0]), 0);
    chk("t4_rx2", 32'(rx[0]), 'h88);
    req[0] = 4'b0000;
    wait_idle(0);
    req_data[0] = 32'h000000A5;
    req[0] = 4'b0001;
    wait_grant(0, gr, md, since);
    chk("t5_grant", 32'(gr), 'h1);
    for (int i = 0; i < 20 && cs[0]; i++) @(negedge clk);
    chk("t5_cs_low", 32'(cs[0]), 0);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_out", 32'({grant[0], ack[0], tmo[0], rx[0], busy[0], launch[0], mdata[0]}), 0);
    req[0] = 4'b1111;
    @(negedge clk);
    rst_n = 1'b1;
    bad = 1'b0;
    n = 0;
    while (!cs[0] && n < 50) begin
      if (grant[0] != 0) bad = 1'b1;
      @(negedge clk);
      n++;
    end
    chk("t5_no_grant", 32'(bad), 0);
    wait_grant(0, gr, md, since);
    chk("t5_first", 32'(gr), 'h1);
    wait_ack(0, a);
    req[0] = 4'b0000;
    chk("t5_ack", 32'(a), 'h1);
    wait_idle(0);
    req_data[1] = 32'h33001100;
    req[1] = 4'b1010;
    for (int i = 0; i < 3; i++) begin
      wait_grant(1, gr, md, since);
      chk("t6_grant", 32'(gr), 32'(eg6[i]));
      chk("t6_mdata", 32'(md), 32'(em6[i]));
      if (i > 0) chk("t6_gap", 32'(since), 3);
    end
    req[1] = 4'b0000;
    wait_idle(1);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d passed so far", n_pass, n_chk);
    $fatal(1);
  end
endmodule

// File: doc/spi_master_arbiter.md
# spi_master_arbiter

Shares one SPI_FPGA_MASTER between NUM_REQ independent requesters on the same clock. Round-robin grant, one transfer in flight at a time. Drives the master's launch and transmit-data inputs, tracks the transfer via CS, and returns the received word with a per-requester acknowledge. Enforces an inter-transfer gap and a launch watchdog. Sits between user logic and the master's IN_LAUNCH_MASTER / IN_MASTER_DATA / CS / OUT_MASTER_RECEIVE_DATA pins.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- PACK_LENGTH, 8, SPI word width; must equal the master's PACK_LENGTH
- GAP_CLOCKS, 64, idle clocks after CS rises before the next grant (0 allowed)
- LAUNCH_TIMEOUT, 1023, clocks to wait for CS to fall after launch before aborting
- IN_CLOCK  in  1  system clock, same as the master's clock
- IN_RESET_N  in  1  asynchronous, active-low reset
- IN_REQ  in  NUM_REQ  level request per requester; held until its OUT_ACK bit pulses
- IN_REQ_DATA  in  NUM_REQ*PACK_LENGTH  flat transmit words; requester k at [k*PACK_LENGTH +: PACK_LENGTH]
- OUT_GRANT  out  NUM_REQ  one-hot owner of the current transfer; 0 when idle
- OUT_ACK  out  NUM_REQ  one-clock completion pulse to the owner
- OUT_TIMEOUT  out  1  high together with OUT_ACK when the transfer was aborted
- OUT_RX_DATA  out  PACK_LENGTH  last received word, valid from the OUT_ACK cycle until the next OUT_ACK
- OUT_BUSY  out  1  high in every state except IDLE
- OUT_LAUNCH_MASTER  out  1  to master IN_LAUNCH_MASTER
- OUT_MASTER_DATA  out  PACK_LENGTH  to master IN_MASTER_DATA
- IN_MASTER_CS  in  1  master CS (active-low)
- IN_MASTER_RECEIVE_DATA  in  PACK_LENGTH  master OUT_MASTER_RECEIVE_DATA

## Operation
- States: IDLE, LAUNCH, ACTIVE, DONE, GAP.
- IDLE: if IN_MASTER_CS=1 and IN_REQ≠0, pick the winner by round-robin starting at last_owner+1 (mod NUM_REQ). Latch its word into OUT_MASTER_DATA, set OUT_GRANT, set OUT_LAUNCH_MASTER=1, go to LAUNCH. If IN_MASTER_CS=0, no grant; wait for CS to rise (covers reset during a transfer).
- LAUNCH: hold launch and data. Sampling IN_MASTER_CS=0 clears launch and goes to ACTIVE. The timeout counter hits LAUNCH_TIMEOUT → clear launch, set abort flag, go to DONE.
- ACTIVE: sampling IN_MASTER_CS=1 → capture IN_MASTER_RECEIVE_DATA into OUT_RX_DATA, go to DONE.
- DONE (1 clock): OUT_ACK=OUT_GRANT, OUT_TIMEOUT=abort flag. last_owner updated. OUT_GRANT cleared at exit. Go to GAP, or to IDLE if GAP_CLOCKS=0. On abort, OUT_RX_DATA is left unchanged.
- GAP: count GAP_CLOCKS clocks, then IDLE.
- A requester still asserting IN_REQ the clock after its ACK is a new request and goes to the back of the round-robin order.
- IN_REQ_DATA is sampled only at grant. Later changes have no effect.
- Deassertion of a request after grant is ignored; the transfer completes and ACK still pulses.
- Counters are $clog2(max(GAP_CLOCKS,LAUNCH_TIMEOUT)+1) bits and saturate; no wrap.

## Timing
- Reset (asynchronous assert, synchronous release): state IDLE; last_owner=NUM_REQ-1 so requester 0 has first priority. All outputs 0: OUT_GRANT, OUT_ACK, OUT_TIMEOUT, OUT_RX_DATA, OUT_BUSY, OUT_LAUNCH_MASTER, OUT_MASTER_DATA.
- Request to launch: IN_REQ sampled high at edge n → OUT_GRANT, OUT_MASTER_DATA, OUT_LAUNCH_MASTER valid after edge n.
- CS falling sampled at edge m → OUT_LAUNCH_MASTER low after edge m.
- CS rising sampled at edge r → OUT_RX_DATA updated after edge r; OUT_ACK high for the clock after edge r+1.
- The next grant is no earlier than edge r+2+GAP_CLOCKS.
- All outputs are registered. IN_MASTER_CS is used directly because it is synchronous to IN_CLOCK.

## Structure
- Package spi_arb_pkg: state enumeration, and the localparams for counter width and round-robin pointer width.
- Sub-module spi_rr_picker: combinational round-robin picker. Inputs: request vector and last_owner. Outputs: one-hot winner and its index.

## Test plan
- Single requester, IN_REQ=4'b0001, data 8'hA5, slave loopback: one launch, OUT_ACK[0] pulses once, and OUT_RX_DATA equals the slave's returned word.
- All four requesting continuously with data 8'h10/8'h20/8'h30/8'h40: grant order 0,1,2,3,0. Master transmit words are in the same order. Between consecutive CS rise and next launch there are ≥ GAP_CLOCKS+2 clocks.
- Requester 2 changes IN_REQ_DATA from 8'h55 to 8'hFF one clock after grant: 8'h55 is transmitted.
- CS held high (master stubbed) with LAUNCH_TIMEOUT=15: after 15 clocks, launch drops and OUT_ACK[k] and OUT_TIMEOUT pulse together. OUT_RX_DATA is unchanged and the next requester is granted after the gap.
- IN_RESET_N pulsed low while CS=0 mid-transfer: all outputs are 0 immediately. No grant occurs until CS rises, then requester 0 is granted first.
- GAP_CLOCKS=0, requesters 1 and 3 requesting: back-to-back transfers, with grant two clocks after each CS rise.
